muldiv_ctrl: RTL and testbench

Multicycle multiply/divide sequencer for the MIPS datapath, executing MULT, MULTU, DIV and DIVU over WIDTH iterations into the architectural HI/LO registers. It sits beside the ALU and is driven by the main control unit, which raises Start with the decoded operation and holds its own FSM in a wait state while Busy is high. It also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_ctrl.sv | 155 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
//   muldiv_op_t    : decoded operation (MULT, MULTU, DIV, DIVU)
//   muldiv_state_t : sequencer FSM states
//   step_mode_t    : iteration kind for the combinational step
//   MULDIV_WIDTH / MULDIV_CNT_W : default operand width and its counter width
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIXUP,
    S_DONE
  } muldiv_state_t;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_t;

  // Op encoding: bit 1 selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(muldiv_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(muldiv_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bus between the main control unit and the multiply/divide sequencer.
//   master : control unit (drives start/op/a/b and MTHI/MTLO writes)
//   slave  : muldiv_ctrl  (drives busy/done/div_zero and the HI/LO values)
interface muldiv_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_write;
  logic             lo_write;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_write, lo_write, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_write, lo_write, wdata,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide core.
//   mode     : STEP_MUL (shift-add) or STEP_DIV (restoring shift-subtract)
//   acc      : 2*WIDTH accumulator {upper, lower}
//   operand  : multiplicand (multiply) or divisor (divide)
//   acc_next : accumulator after the iteration; its lower half collects the
//              product bits (entering at the top) or quotient bits (entering
//              at the bottom)
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  step_mode_t         mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;    // upper half plus optional multiplicand, with carry
  logic [WIDTH:0]   trial;  // partial remainder with next dividend bit shifted in
  logic [WIDTH-1:0] diff;
  logic             fits;

  // NOTE: every output of a combinational block gets a value on every path,
  // starting with a default, so no latch can be inferred.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    fits     = trial >= {1'b0, operand};
    // The true difference is below the divisor whenever it is used, so the
    // low WIDTH bits are exact.
    diff     = trial[WIDTH-1:0] - operand;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (mode == STEP_DIV) begin
      acc_next = {(fits ? diff : trial[WIDTH-1:0]), acc[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer with the architectural HI/LO
// registers, plus MTHI/MTLO write servicing.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if.slave (start/op/a/b, hi_write/lo_write/wdata in;
//           busy/done/div_zero/hi/lo out)
// Signed ops run on operand magnitudes through the unsigned core; the signs
// are restored in FIXUP, so HI/LO only ever see final results.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  muldiv_state_t      state, state_next;
  muldiv_op_t         op_q;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               neg_result;  // product / quotient must be negated
  logic               neg_rem;     // remainder takes the dividend's sign
  logic               div_zero_q;

  // Request decode, valid while idle.
  logic               accept;
  logic               req_signed, req_div, req_div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // FIXUP results.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  step_mode_t         step_mode;

  always_comb begin
    accept       = (state == S_IDLE) && bus.start;
    req_signed   = op_is_signed(bus.op);
    req_div      = op_is_div(bus.op);
    req_div_zero = req_div && (bus.b == '0);
    // Magnitude of the most negative value is itself read as unsigned.
    a_mag        = (req_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag        = (req_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  always_comb begin
    prod_fix = neg_result ? -acc : acc;
    quo_fix  = neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  assign step_mode = (state == S_DIV) ? STEP_DIV : STEP_MUL;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode    (step_mode),
    .acc     (acc),
    .operand (operand),
    .acc_next(acc_next)
  );

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_div_zero) state_next = S_DONE;
          else if (req_div) state_next = S_DIV;
          else              state_next = S_MULT;
        end
      end
      S_MULT, S_DIV: begin
        if (count == CNT_W'(1)) state_next = S_FIXUP;
      end
      S_FIXUP: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: the accumulator and operand registers are reset too, so an aborted
  // operation leaves no stale partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_MULT;
      count      <= '0;
      acc        <= '0;
      operand    <= '0;
      neg_result <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q       <= bus.op;
            count      <= CNT_W'(WIDTH);
            neg_result <= req_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem    <= req_signed && bus.a[WIDTH-1];
            div_zero_q <= req_div_zero;
            if (req_div) begin
              acc     <= {{WIDTH{1'b0}}, a_mag};
              operand <= b_mag;
            end else begin
              acc     <= {{WIDTH{1'b0}}, b_mag};
              operand <= a_mag;
            end
          end else begin
            // MTHI/MTLO lose to an accepted Start in the same cycle.
            if (bus.hi_write) hi_q <= bus.wdata;
            if (bus.lo_write) lo_q <= bus.wdata;
          end
        end
        S_MULT, S_DIV: begin
          acc   <= acc_next;
          count <= count - CNT_W'(1);
        end
        S_FIXUP: begin
          case (op_q)
            OP_DIV, OP_DIVU: begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
            default: {hi_q, lo_q} <= prod_fix;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus randomized
// operations compared against a plain-arithmetic HI/LO model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;  // Start edge to Done cycle, in cycles

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Architectural model state.
  logic [W-1:0] hi_m, lo_m;
  logic         dz_m;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_op(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz_m = 1'b0;
    case (op)
      OP_MULT: begin
        p = sa * sb;
        hi_m = p[63:32]; lo_m = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        hi_m = p[63:32]; lo_m = p[31:0];
      end
      OP_DIV: begin
        if (b == 0) dz_m = 1'b1;
        else begin
          q = sa / sb; r = sa % sb;
          lo_m = q[31:0]; hi_m = r[31:0];
        end
      end
      default: begin
        if (b == 0) dz_m = 1'b1;
        else begin
          lo_m = a / b; hi_m = a % b;
        end
      end
    endcase
  endtask

  // Issue one op and wait (bounded) for Done. Returns at the negedge inside
  // the Done cycle. lat counts cycles from the accepting edge to Done.
  task automatic do_op(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cycles, output bit stable);
    logic [W-1:0] h0, l0;
    h0 = bus.hi; l0 = bus.lo;
    stable = 1'b1; busy_cycles = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_cycles++;
      if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.busy) busy_cycles++;
  endtask

  task automatic mt_write(input logic hw, input logic lw, input logic [W-1:0] data);
    @(negedge clk);
    bus.hi_write = hw; bus.lo_write = lw; bus.wdata = data;
    @(negedge clk);
    bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    if (hw) hi_m = data;
    if (lw) lo_m = data;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++; if (bus.hi !== 32'h0)    $display("FAIL reset_hi: got %h exp 0", bus.hi);    else n_pass++;
    n_total++; if (bus.lo !== 32'h0)    $display("FAIL reset_lo: got %h exp 0", bus.lo);    else n_pass++;
    n_total++; if (bus.busy !== 1'b0)   $display("FAIL reset_busy: got %b exp 0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0)   $display("FAIL reset_done: got %b exp 0", bus.done); else n_pass++;
    n_total++; if (bus.div_zero !== 1'b0) $display("FAIL reset_dz: got %b exp 0", bus.div_zero); else n_pass++;
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
  endtask

  task automatic test_multu_max();
    int lat, bc; bit st;
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, st);
    model_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_total++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h exp fffffffe", bus.hi); else n_pass++;
    n_total++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h exp 00000001", bus.lo); else n_pass++;
    n_total++; if (lat !== LAT) $display("FAIL multu_latency: got %0d exp %0d", lat, LAT); else n_pass++;
    n_total++; if (bc !== LAT)  $display("FAIL multu_busy_cycles: got %0d exp %0d", bc, LAT); else n_pass++;
    n_total++; if (st !== 1'b1) $display("FAIL multu_hilo_stable: got %b exp 1", st); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.done !== 1'b0) $display("FAIL multu_done_pulse: got %b exp 0", bus.done); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL multu_busy_fall: got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_mult_signed();
    int lat, bc; bit st;
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bc, st);
    model_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    n_total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h exp ffffffff", bus.hi); else n_pass++;
    n_total++; if (bus.lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h exp ffffffeb", bus.lo); else n_pass++;
  endtask

  task automatic test_div_sequence();
    int lat, bc; bit st;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, st);
    model_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    n_total++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h exp fffffffd", bus.lo); else n_pass++;
    n_total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h exp ffffffff", bus.hi); else n_pass++;
    n_total++; if (lat !== LAT) $display("FAIL div_latency: got %0d exp %0d", lat, LAT); else n_pass++;
    do_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, lat, bc, st);
    model_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    n_total++; if (bus.lo !== 32'h7FFF_FFFC) $display("FAIL divu_lo: got %h exp 7ffffffc", bus.lo); else n_pass++;
    n_total++; if (bus.hi !== 32'h0000_0001) $display("FAIL divu_hi: got %h exp 00000001", bus.hi); else n_pass++;
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, st);
    model_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    n_total++; if (bus.lo !== 32'h8000_0000) $display("FAIL divovf_lo: got %h exp 80000000", bus.lo); else n_pass++;
    n_total++; if (bus.hi !== 32'h0)         $display("FAIL divovf_hi: got %h exp 0", bus.hi); else n_pass++;
    n_total++; if (bus.div_zero !== 1'b0)    $display("FAIL divovf_dz: got %b exp 0", bus.div_zero); else n_pass++;
  endtask

  task automatic test_div_zero();
    int lat, bc; bit st;
    mt_write(1'b1, 1'b0, 32'h1234_5678);
    n_total++; if (bus.hi !== 32'h1234_5678) $display("FAIL mthi_value: got %h exp 12345678", bus.hi); else n_pass++;
    do_op(OP_DIV, 32'd99, 32'd0, lat, bc, st);
    model_op(OP_DIV, 32'd99, 32'd0);
    n_total++; if (lat !== 1)                $display("FAIL dz_latency: got %0d exp 1", lat); else n_pass++;
    n_total++; if (bus.div_zero !== 1'b1)    $display("FAIL dz_flag: got %b exp 1", bus.div_zero); else n_pass++;
    n_total++; if (bus.hi !== 32'h1234_5678) $display("FAIL dz_hi_kept: got %h exp 12345678", bus.hi); else n_pass++;
    n_total++; if (bus.lo !== lo_m)          $display("FAIL dz_lo_kept: got %h exp %h", bus.lo, lo_m); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0)     $display("FAIL dz_busy_one_cycle: got %b exp 0", bus.busy); else n_pass++;
    n_total++; if (bus.div_zero !== 1'b1) $display("FAIL dz_flag_held: got %b exp 1", bus.div_zero); else n_pass++;
    // The next accepted Start clears the flag right away.
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    n_total++; if (bus.div_zero !== 1'b0) $display("FAIL dz_cleared: got %b exp 0", bus.div_zero); else n_pass++;
    lat = 1;
    while (!bus.done && lat < 200) begin @(negedge clk); lat++; end
    model_op(OP_MULTU, 32'd2, 32'd3);
    n_total++; if (bus.lo !== 32'd6) $display("FAIL dz_after_op_lo: got %h exp 6", bus.lo); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [W-1:0] a, b;
    a = 32'h0001_2345; b = 32'hFFFF_0003;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; lat = 1;
    repeat (5) begin @(negedge clk); lat++; end
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1; bus.b = 32'd0;
    bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    lat++;
    bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    while (!bus.done && lat < 200) begin @(negedge clk); lat++; end
    model_op(OP_MULT, a, b);
    n_total++; if (bus.hi !== hi_m) $display("FAIL busy_ign_hi: got %h exp %h", bus.hi, hi_m); else n_pass++;
    n_total++; if (bus.lo !== lo_m) $display("FAIL busy_ign_lo: got %h exp %h", bus.lo, lo_m); else n_pass++;
    n_total++; if (lat !== LAT)     $display("FAIL busy_ign_latency: got %0d exp %0d", lat, LAT); else n_pass++;
    n_total++; if (bus.div_zero !== 1'b0) $display("FAIL busy_ign_dz: got %b exp 0", bus.div_zero); else n_pass++;
  endtask

  task automatic test_mt_writes();
    int lat;
    mt_write(1'b1, 1'b1, 32'hA5A5_0F0F);
    n_total++; if (bus.hi !== 32'hA5A5_0F0F) $display("FAIL mt_both_hi: got %h exp a5a50f0f", bus.hi); else n_pass++;
    n_total++; if (bus.lo !== 32'hA5A5_0F0F) $display("FAIL mt_both_lo: got %h exp a5a50f0f", bus.lo); else n_pass++;
    mt_write(1'b0, 1'b1, 32'h0000_BEEF);
    n_total++; if (bus.hi !== 32'hA5A5_0F0F) $display("FAIL mtlo_hi_kept: got %h exp a5a50f0f", bus.hi); else n_pass++;
    n_total++; if (bus.lo !== 32'h0000_BEEF) $display("FAIL mtlo_lo: got %h exp 0000beef", bus.lo); else n_pass++;
    // Writes in the same cycle as an accepted Start are dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'd3;
    bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0; lat = 1;
    n_total++; if (bus.hi !== 32'hA5A5_0F0F) $display("FAIL mt_vs_start_hi_now: got %h exp a5a50f0f", bus.hi); else n_pass++;
    while (!bus.done && lat < 200) begin @(negedge clk); lat++; end
    model_op(OP_MULTU, 32'd2, 32'd3);
    n_total++; if (bus.hi !== 32'd0) $display("FAIL mt_vs_start_hi: got %h exp 0", bus.hi); else n_pass++;
    n_total++; if (bus.lo !== 32'd6) $display("FAIL mt_vs_start_lo: got %h exp 6", bus.lo); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit st;
    do_op(OP_MULTU, 32'd7, 32'd9, lat, bc, st);
    model_op(OP_MULTU, 32'd7, 32'd9);
    n_total++; if (bus.lo !== 32'd63) $display("FAIL b2b_first_lo: got %h exp 3f", bus.lo); else n_pass++;
    // Start raised during the Done cycle and held.
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL b2b_not_taken_in_done: got %b exp 0", bus.busy); else n_pass++;
    @(negedge clk);
    bus.start = 1'b0; lat = 1;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL b2b_taken_in_idle: got %b exp 1", bus.busy); else n_pass++;
    while (!bus.done && lat < 200) begin @(negedge clk); lat++; end
    model_op(OP_DIVU, 32'd100, 32'd7);
    n_total++; if (lat !== LAT)       $display("FAIL b2b_latency: got %0d exp %0d", lat, LAT); else n_pass++;
    n_total++; if (bus.lo !== 32'd14) $display("FAIL b2b_lo: got %h exp e", bus.lo); else n_pass++;
    n_total++; if (bus.hi !== 32'd2)  $display("FAIL b2b_hi: got %h exp 2", bus.hi); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int lat, bc; bit st;
    mt_write(1'b1, 1'b1, 32'h5A5A_5A5A);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.hi !== 32'h0)      $display("FAIL rst_mid_hi: got %h exp 0", bus.hi); else n_pass++;
    n_total++; if (bus.lo !== 32'h0)      $display("FAIL rst_mid_lo: got %h exp 0", bus.lo); else n_pass++;
    n_total++; if (bus.busy !== 1'b0)     $display("FAIL rst_mid_busy: got %b exp 0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0)     $display("FAIL rst_mid_done: got %b exp 0", bus.done); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    do_op(OP_MULTU, 32'd3, 32'd5, lat, bc, st);
    model_op(OP_MULTU, 32'd3, 32'd5);
    n_total++; if (bus.lo !== 32'd15) $display("FAIL rst_fresh_lo: got %h exp f", bus.lo); else n_pass++;
    n_total++; if (bus.hi !== 32'd0)  $display("FAIL rst_fresh_hi: got %h exp 0", bus.hi); else n_pass++;
    n_total++; if (lat !== LAT)       $display("FAIL rst_fresh_latency: got %0d exp %0d", lat, LAT); else n_pass++;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int lat, bc, exp_lat; bit st;
    muldiv_op_t op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom));
      op = muldiv_op_t'(2'($urandom_range(0, 3)));
      a  = pick_operand();
      b  = pick_operand();
      do_op(op, a, b, lat, bc, st);
      model_op(op, a, b);
      exp_lat = dz_m ? 1 : LAT;
      n_total++; if (bus.hi !== hi_m) $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h exp %h", i, op, a, b, bus.hi, hi_m); else n_pass++;
      n_total++; if (bus.lo !== lo_m) $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h exp %h", i, op, a, b, bus.lo, lo_m); else n_pass++;
      n_total++; if (bus.div_zero !== dz_m) $display("FAIL rnd%0d_dz: got %b exp %b", i, bus.div_zero, dz_m); else n_pass++;
      n_total++; if (lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d exp %0d", i, lat, exp_lat); else n_pass++;
      n_total++; if (st !== 1'b1) $display("FAIL rnd%0d_hilo_stable: got %b exp 1", i, st); else n_pass++;
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.op       = OP_MULT;
    bus.a        = '0;
    bus.b        = '0;
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b0;
    bus.wdata    = '0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div_sequence();
    test_div_zero();
    test_busy_ignore();
    test_mt_writes();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
